button_pulse_frontend: RTL and testbench
========================================

Name: button_pulse_frontend

Overview:
Input front end for the two-car, seven-floor elevator controller. It synchronises and debounces the raw hall and cabin push-buttons, then emits the single-cycle "new button" pulse vectors that the controller consumes (newRealFloorButton, newInternalButton1, newInternalButton2). It takes the controller's lamp vectors back as inputs, so a press on a button whose request is already registered produces no pulse.

Parameters:
TICK_DIV, 40, clk cycles per debounce sample tick (>=2)
STABLE_TICKS, 4, consecutive ticks a synchronised sample must differ from the debounced state before that state flips (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
rawRealFloorButton  in  12  raw hall buttons, asynchronous, 1 = pressed
rawInternalButton1  in  9 [9:1]  raw car-1 cabin buttons
rawInternalButton2  in  9 [9:1]  raw car-2 cabin buttons
currentRealFloorButton  in  12  hall lamp state from controller
currentInternalButton1  in  9 [9:1]  car-1 lamp state
currentInternalButton2  in  9 [9:1]  car-2 lamp state
newRealFloorButton  out  12  one-cycle press pulses to controller
newInternalButton1  out  9 [9:1]  one-cycle press pulses
newInternalButton2  out  9 [9:1]  one-cycle press pulses
debouncedButtons  out  30  debounced level, packed as {raw2[9:1], raw1[9:1], rawRFB[11:0]}

Behaviour:
- 30 independent button channels with identical logic; the bit packing follows debouncedButtons.
- Reset asserted: synchronisers, prescaler, all stability counters, debounced states and all outputs go to 0 immediately; they stay 0 while reset=0.
- Synchroniser: two flops per raw bit. Only the second-stage value (sync) is used downstream.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps; starts at 0 on reset release.
  - tick=1 for exactly one cycle, when the count equals TICK_DIV-1.
- Per-channel debounce FSM, state deb in {RELEASED, PRESSED}, plus a saturating counter cnt of width clog2(STABLE_TICKS+1):
  - On a tick with sync != deb: cnt increments. If cnt+1 == STABLE_TICKS, deb toggles and cnt clears in that same cycle.
  - On a tick with sync == deb: cnt clears (glitch rejection; the next change restarts the count).
  - No tick: cnt and deb hold.
- Pulse generation (registered):
  - new*[i]=1 for exactly the cycle after deb goes RELEASED->PRESSED, and only if the matching current* lamp bit is 0 in that cycle.
  - Otherwise new*[i]=0.
  - PRESSED->RELEASED produces no pulse.
- Latency, raw rise to pulse, with raw stable: min 2+(STABLE_TICKS-1)*TICK_DIV+2 cycles, max 2+STABLE_TICKS*TICK_DIV+2 cycles.
- A held button yields one pulse only. Another pulse needs a debounced release (STABLE_TICKS ticks low) and then a fresh debounced press.
- Simultaneous presses on any number of channels in the same tick: all matching pulses assert in the same cycle. There is no arbitration and no loss.
- A lamp that turns on between deb toggling and the pulse cycle suppresses the pulse. A lamp turning off later does not create a retroactive pulse.
- Reset mid-debounce: all progress is discarded. After release, a still-held button needs a full STABLE_TICKS window and then pulses once.
- Bounce shorter than one tick period may be missed entirely. This is intended.

Test Plan:
(Bench parameters for all scenarios: TICK_DIV=4, STABLE_TICKS=3. Lamps are 0 unless stated.)
- Clean press: rawRealFloorButton=12'h001 held for 40 cycles from reset release -> newRealFloorButton=12'h001 for exactly 1 cycle, 12–16 cycles after raw rise. debouncedButtons[0]=1 from then on; no second pulse while held.
- Bounce: rawInternalButton1[3] toggles every 3 cycles for 30 cycles, then stays high -> no pulse during the bounce; one pulse ≤16 cycles after it settles high.
- Lamp suppression: currentInternalButton2[5]=1 and rawInternalButton2[5] pressed -> debouncedButtons bit 25 goes 1, but newInternalButton2 stays 9'h000.
- Simultaneous: rawRealFloorButton=12'b1000_0000_0001, rawInternalButton1=9'h102, rawInternalButton2=9'h001 asserted in the same cycle -> all three pulse vectors show those exact values in one common cycle.
- Re-press: press, release for 16 cycles, press again -> exactly two pulses. A release shorter than 8 cycles -> exactly one pulse.
- Reset mid-operation: reset=0 for 5 cycles while a button is held, 8 cycles into its debounce -> all outputs 0 immediately. After release, exactly one pulse, 12–16 cycles later.

Source files
------------

// File: rtl/button_pulse_frontend_if.sv
// Button/lamp/pulse bundle between the controller side (master) and the button front end (slave).
interface button_pulse_frontend_if;
    logic [11:0] rawRealFloorButton;
    logic [9:1]  rawInternalButton1;
    logic [9:1]  rawInternalButton2;
    logic [11:0] currentRealFloorButton;
    logic [9:1]  currentInternalButton1;
    logic [9:1]  currentInternalButton2;
    logic [11:0] newRealFloorButton;
    logic [9:1]  newInternalButton1;
    logic [9:1]  newInternalButton2;
    logic [29:0] debouncedButtons;

    modport master (
        output rawRealFloorButton, rawInternalButton1, rawInternalButton2,
        output currentRealFloorButton, currentInternalButton1, currentInternalButton2,
        input  newRealFloorButton, newInternalButton1, newInternalButton2,
        input  debouncedButtons
    );

    modport slave (
        input  rawRealFloorButton, rawInternalButton1, rawInternalButton2,
        input  currentRealFloorButton, currentInternalButton1, currentInternalButton2,
        output newRealFloorButton, newInternalButton1, newInternalButton2,
        output debouncedButtons
    );
endinterface

// File: rtl/button_pulse_frontend.sv
// Syncs + debounces 30 push-buttons, emits one-cycle press pulses unless the lamp is already lit.
// Latency raw->pulse: 2 + (STABLE_TICKS-1..STABLE_TICKS)*TICK_DIV + 2 cycles.
// No backpressure: pulses are fire-and-forget, simultaneous presses all pulse together.
module button_pulse_frontend #(
    parameter int TICK_DIV     = 40,
    parameter int STABLE_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    button_pulse_frontend_if.slave bus
);
    localparam int N  = 30;
    localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} deb_t;

    logic [N-1:0]  raw_all;
    logic [N-1:0]  lamp_all;
    logic [N-1:0]  sync_a;
    logic [N-1:0]  sync_b;
    logic [PW-1:0] pre;
    logic          tick;
    deb_t          deb_q [N];
    deb_t          deb_n [N];
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_n [N];
    logic [N-1:0]  deb_vec;
    logic [N-1:0]  deb_d;
    logic [N-1:0]  pulse_q;

    assign raw_all  = {bus.rawInternalButton2, bus.rawInternalButton1, bus.rawRealFloorButton};
    assign lamp_all = {bus.currentInternalButton2, bus.currentInternalButton1,
                       bus.currentRealFloorButton};
    assign tick     = (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
            pre    <= '0;
        end else begin
            sync_a <= raw_all;
            sync_b <= sync_a;
            pre    <= tick ? '0 : pre + PW'(1);
        end
    end

    // A tick that sees agreement restarts the window, so only an unbroken run of disagreeing ticks flips deb.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            deb_n[i] = deb_q[i];
            cnt_n[i] = cnt_q[i];
            if (tick) begin
                if (sync_b[i] != logic'(deb_q[i])) begin
                    if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
                        deb_n[i] = (deb_q[i] == PRESSED) ? RELEASED : PRESSED;
                        cnt_n[i] = '0;
                    end else begin
                        cnt_n[i] = cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_n[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                deb_q[i] <= RELEASED;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                deb_q[i] <= deb_n[i];
                cnt_q[i] <= cnt_n[i];
            end
        end
    end

    always_comb begin
        deb_vec = '0;
        for (int i = 0; i < N; i++) begin
            deb_vec[i] = (deb_q[i] == PRESSED);
        end
    end

    // Lamp is sampled in the cycle deb is first high, so a lamp lit in that window suppresses the pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_d   <= '0;
            pulse_q <= '0;
        end else begin
            deb_d   <= deb_vec;
            pulse_q <= deb_vec & ~deb_d & ~lamp_all;
        end
    end

    assign bus.newRealFloorButton = pulse_q[11:0];
    assign bus.newInternalButton1 = pulse_q[20:12];
    assign bus.newInternalButton2 = pulse_q[29:21];
    assign bus.debouncedButtons   = deb_vec;
endmodule

// File: tb/tb_button_pulse_frontend.sv
// Directed bench for button_pulse_frontend with TICK_DIV=4, STABLE_TICKS=3.
module tb_button_pulse_frontend;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pcount = 0;
    int   first = -1;
    logic [11:0] f_rfb;
    logic [9:1]  f_i1;
    logic [9:1]  f_i2;

    button_pulse_frontend_if bus ();

    button_pulse_frontend #(.TICK_DIV(4), .STABLE_TICKS(3)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0;
        pcount = 0;
        first = -1;
        f_rfb = '0;
        f_i1 = '0;
        f_i2 = '0;
    endtask

    // Advance n cycles, sampling on the falling edge and recording pulse cycles.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if ((|bus.newRealFloorButton) || (|bus.newInternalButton1) || (|bus.newInternalButton2)) begin
                pcount++;
                if (pcount == 1) begin
                    first = cyc;
                    f_rfb = bus.newRealFloorButton;
                    f_i1  = bus.newInternalButton1;
                    f_i2  = bus.newInternalButton2;
                end
            end
        end
    endtask

    initial begin
        bus.rawRealFloorButton     = '0;
        bus.rawInternalButton1     = '0;
        bus.rawInternalButton2     = '0;
        bus.currentRealFloorButton = '0;
        bus.currentInternalButton1 = '0;
        bus.currentInternalButton2 = '0;

        // Reset state, with a raw button held during reset
        bus.rawRealFloorButton = 12'h800;
        run(4);
        check("rst_deb", {2'b0, bus.debouncedButtons}, 32'h0);
        check("rst_new_rfb", {20'b0, bus.newRealFloorButton}, 32'h0);
        check("rst_new_i1", {23'b0, bus.newInternalButton1}, 32'h0);
        bus.rawRealFloorButton = '0;
        rst_n = 1'b1;
        run(20);

        // Clean press
        clear_stats();
        bus.rawRealFloorButton = 12'h001;
        run(40);
        check("clean_count", pcount, 1);
        check("clean_val", {20'b0, f_rfb}, 32'h001);
        check("clean_lat", (first >= 12 && first <= 16), 1);
        check("clean_deb", {2'b0, bus.debouncedButtons}, 32'h0000_0001);
        clear_stats();
        bus.rawRealFloorButton = '0;
        run(20);
        check("release_nopulse", pcount, 0);
        check("release_deb", {2'b0, bus.debouncedButtons}, 32'h0);

        // Bounce: 3 high / 3 low never gives three agreeing ticks
        clear_stats();
        for (int i = 0; i < 10; i++) begin
            bus.rawInternalButton1[3] = (i % 2 == 0);
            run(3);
        end
        check("bounce_nopulse", pcount, 0);
        clear_stats();
        bus.rawInternalButton1[3] = 1'b1;
        run(20);
        check("bounce_count", pcount, 1);
        check("bounce_val", {23'b0, f_i1}, 32'h004);
        check("bounce_lat", (first >= 1 && first <= 16), 1);
        bus.rawInternalButton1 = '0;
        run(20);

        // Lamp suppression
        clear_stats();
        bus.currentInternalButton2[5] = 1'b1;
        bus.rawInternalButton2[5] = 1'b1;
        run(24);
        check("lamp_nopulse", pcount, 0);
        check("lamp_deb25", {31'b0, bus.debouncedButtons[25]}, 32'h1);
        bus.rawInternalButton2 = '0;
        run(20);
        bus.currentInternalButton2 = '0;

        // Simultaneous presses on three vectors
        clear_stats();
        bus.rawRealFloorButton = 12'b1000_0000_0001;
        bus.rawInternalButton1 = 9'h102;
        bus.rawInternalButton2 = 9'h001;
        run(24);
        check("simul_count", pcount, 1);
        check("simul_rfb", {20'b0, f_rfb}, 32'h801);
        check("simul_i1", {23'b0, f_i1}, 32'h102);
        check("simul_i2", {23'b0, f_i2}, 32'h001);
        check("simul_lat", (first >= 12 && first <= 16), 1);
        check("simul_deb", {2'b0, bus.debouncedButtons}, 32'h0030_2801);
        bus.rawRealFloorButton = '0;
        bus.rawInternalButton1 = '0;
        bus.rawInternalButton2 = '0;
        run(20);

        // Re-press after a full release window
        clear_stats();
        bus.rawRealFloorButton = 12'h010;
        run(20);
        bus.rawRealFloorButton = '0;
        run(16);
        bus.rawRealFloorButton = 12'h010;
        run(20);
        check("repress_two", pcount, 2);
        bus.rawRealFloorButton = '0;
        run(20);

        // Short release is rejected
        clear_stats();
        bus.rawRealFloorButton = 12'h010;
        run(20);
        bus.rawRealFloorButton = '0;
        run(4);
        bus.rawRealFloorButton = 12'h010;
        run(20);
        check("shortrel_one", pcount, 1);
        bus.rawRealFloorButton = '0;
        run(20);

        // Reset mid-debounce, with another button already debounced
        clear_stats();
        bus.rawInternalButton1[1] = 1'b1;
        run(20);
        check("held_pulse", pcount, 1);
        bus.rawRealFloorButton = 12'h080;
        run(8);
        check("pre_rst_deb", {2'b0, bus.debouncedButtons}, 32'h0000_1000);
        rst_n = 1'b0;
        #1;
        check("midrst_deb", {2'b0, bus.debouncedButtons}, 32'h0);
        check("midrst_new", {bus.newRealFloorButton, bus.newInternalButton1, bus.newInternalButton2}, 32'h0);
        run(5);
        check("midrst_hold", {2'b0, bus.debouncedButtons}, 32'h0);
        clear_stats();
        rst_n = 1'b1;
        run(24);
        check("postrst_count", pcount, 1);
        check("postrst_rfb", {20'b0, f_rfb}, 32'h080);
        check("postrst_i1", {23'b0, f_i1}, 32'h001);
        check("postrst_lat", (first >= 12 && first <= 16), 1);
        check("postrst_deb", {2'b0, bus.debouncedButtons}, 32'h0000_1080);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
